// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Types and constants shared by the decode-stage blocks:
//                register address, 32-bit word and the register-write
//                request carried through the pipeline registers.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs;

    localparam int REG_NUM = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] uint32_t;

    // Register write request as carried in pipe_ex/pipe_mm/pipe_wb
    typedef struct packed {
        logic      we;
        reg_addr_t waddr;
        uint32_t   wrdata;
    } reg_wreq_t;

endpackage
`default_nettype wire

// File: rtl/regfile_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_reg
//  Description : HI/LO register pair. Both halves are committed together;
//                synchronous active-high reset clears both.
//                Optional macro REGFILE_WRITE_BYPASS_EN forwards hi_i/lo_i
//                to the outputs in the cycle they are being written.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_reg
    import cpu_defs::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    hilo_we_i,
    input  uint32_t hi_i,
    input  uint32_t lo_i,
    output uint32_t hi_o,
    output uint32_t lo_o
);

    uint32_t r_hi;
    uint32_t r_lo;

    // Commit HI and LO as a pair; reset overrides any concurrent write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (hilo_we_i) begin
            r_hi <= hi_i;
            r_lo <= lo_i;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    // Pending write is visible immediately, except while reset is held
    always_comb begin
        hi_o = r_hi;
        lo_o = r_lo;
        if (hilo_we_i && !rst) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end
`else
    assign hi_o = r_hi;
    assign lo_o = r_lo;
`endif

endmodule
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module      : regfile
//  Description : MIPS general-purpose register file ($1..$31, $0 reads as
//                zero and has no storage) plus the HI/LO pair. Multi-port
//                combinational reads, multi-port synchronous writes where the
//                highest-index port wins on an address collision.
//                Optional macro REGFILE_WRITE_BYPASS_EN adds same-cycle
//                write-to-read forwarding inside the block.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile
    import cpu_defs::*;
#(
    parameter int READ_PORTS  = 2,
    parameter int WRITE_PORTS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  reg_addr_t [READ_PORTS-1:0]   raddr_i,
    output uint32_t   [READ_PORTS-1:0]   rddata_o,
    input  reg_wreq_t [WRITE_PORTS-1:0]  wreq_i,
    input  logic                         hilo_we_i,
    input  uint32_t                      hi_i,
    input  uint32_t                      lo_i,
    output uint32_t                      hi_o,
    output uint32_t                      lo_o
);

    // $0 is hardwired, so the array starts at index 1
    uint32_t r_regs [REG_NUM-1:1];
    uint32_t [READ_PORTS-1:0] w_rddata;

    // Write commit: ports processed in index order so the last (highest)
    // matching port's non-blocking assignment is the one that lands
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < REG_NUM; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (wreq_i[j].we && (wreq_i[j].waddr != '0)) begin
                    r_regs[wreq_i[j].waddr] <= wreq_i[j].wrdata;
                end
            end
        end
    end

    // Combinational read, with optional forwarding of the in-flight write
    always_comb begin
        w_rddata = '0;
        for (int i = 0; i < READ_PORTS; i++) begin
            if (raddr_i[i] != '0) begin
                w_rddata[i] = r_regs[raddr_i[i]];
            end
`ifdef REGFILE_WRITE_BYPASS_EN
            for (int j = 0; j < WRITE_PORTS; j++) begin
                if (!rst && wreq_i[j].we && (wreq_i[j].waddr != '0) &&
                    (wreq_i[j].waddr == raddr_i[i])) begin
                    w_rddata[i] = wreq_i[j].wrdata;
                end
            end
`endif
        end
    end

    assign rddata_o = w_rddata;

    hilo_reg u_hilo (
        .clk       (clk),
        .rst       (rst),
        .hilo_we_i (hilo_we_i),
        .hi_i      (hi_i),
        .lo_i      (lo_i),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

endmodule
`default_nettype wire

// File: doc/regfile.md
# regfile

MIPS general-purpose register file plus HI/LO pair, sitting directly upstream of `regs_forward` in the decode stage. It stores 31 writable 32-bit registers, with `$0` hardwired to zero. The writeback stage writes it through the same `regs_wreq` request carried in `pipe_wb`. Its combinational read data feeds `regs_forward`, which overlays in-flight EX/MM/WB results.

## Interface
- `READ_PORTS`, 2, number of independent combinational read ports.
- `WRITE_PORTS`, 1, number of write ports; index order sets priority.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `raddr_i`  in  `reg_addr_t[READ_PORTS-1:0]`  read addresses, 5 bits each.
- `rddata_o`  out  `uint32_t[READ_PORTS-1:0]`  read data; drives `regs_rddata_i` of `regs_forward`.
- `wreq_i`  in  `reg_wreq_t[WRITE_PORTS-1:0]`  write requests {`we`, `waddr`, `wrdata`}; driven from `pipe_wb.regs_wreq`.
- `hilo_we_i`  in  1  commit `hi_i`/`lo_i` this cycle.
- `hi_i`, `lo_i`  in  32 each  HI/LO write data.
- `hi_o`, `lo_o`  out  32 each  current HI/LO.

## Operation
- Storage: `regs[31:1]`, 32 bits each, plus `hi` and `lo`. `$0` has no storage.
- Write commit:
  - On a rising edge with `rst`=0, for each port `j` with `we`=1 and `waddr`≠0, `regs[waddr] <= wrdata`.
  - If several ports hit the same address, the highest-index port wins.
  - A write to `waddr`=0 is discarded silently.
- HI/LO: `hilo_we_i`=1 commits both `hi` and `lo` together. There is no partial write.
- Read:
  - `rddata_o[i] = (raddr_i[i]==0) ? 0 : regs[raddr_i[i]]`.
  - Purely combinational. No read enable.
- Reset:
  - When `rst`=1 at a rising edge, all `regs` are cleared to `32'h0` and `hi`/`lo` are cleared to 0, in one cycle.
  - Writes presented in that same cycle are ignored.
  - Reset asserted mid-program takes effect at that edge; no partial-write state survives.
- Reset values of outputs: after the reset edge, `rddata_o` is 0 for every address and `hi_o`/`lo_o` are 0.

## Timing
- Write latency: data presented in cycle N is readable from storage in cycle N+1.
- Same-cycle read of an address being written:
  - Returns the old value, unless the bypass feature is compiled in (see Configuration).
  - Correctness without bypass relies on `regs_forward` forwarding `pipe_wb`. The two blocks must be fed the identical `regs_wreq`.
- Read-to-output path: combinational only, with no registers on `rddata_o`, `hi_o` or `lo_o`.
- There are no stalls or handshakes. The block always accepts writes, since the writeback stage never backpressures.

## Configuration
- `REGFILE_WRITE_BYPASS_EN` defined: internal write-to-read bypass.
  - If any port `j` has `we`=1, `waddr`==`raddr_i[i]` and `waddr`≠0, then `rddata_o[i]` returns `wrdata` of the highest such `j` in the same cycle.
  - Likewise, `hilo_we_i` bypasses `hi_i`/`lo_i` onto `hi_o`/`lo_o`.
  - Bypass is suppressed while `rst`=1.
- Undefined: reads return stored values only. WB forwarding is the sole responsibility of `regs_forward`.

## Structure
- Shared package `cpu_defs` holds:
  - `reg_addr_t` (logic[4:0]) and `uint32_t`.
  - `reg_wreq_t` packed struct {`we`, `waddr`, `wrdata`}, reused inside `pipe_wb_t`/`pipe_mm_t`/`pipe_ex_t`.
  - Constant `REG_NUM`=32.
- One sub-module, `hilo_reg`, holds the HI/LO pair: a synchronous reset register with an optional bypass under the same macro.
- The GPR array is implemented in `regfile` itself.

## Test plan
- Reset: write `$5`=`32'hDEADBEEF`, then hold `rst`=1 for one cycle with a concurrent write `$6`=1 → both `rddata_o` read 0 for `$5` and `$6`, and `hi_o`=`lo_o`=0.
- Basic write/read: cycle 0 write `$3`=`32'h12345678`; cycle 1 read ports 0/1 at `$3`/`$4` → `32'h12345678` / 0.
- `$0` protection: write `$0`=`32'hFFFFFFFF`, then read `$0` → 0 on every port, every cycle.
- Port priority (`WRITE_PORTS`=2): port 0 writes `$7`=`32'hAAAA`, port 1 writes `$7`=`32'hBBBB` in the same cycle → next cycle `$7` reads `32'hBBBB`.
- Same-cycle read/write of `$9` with `wrdata`=`32'h55` and old value `32'h11` → `rddata_o` = `32'h11` without the macro, `32'h55` with `REGFILE_WRITE_BYPASS_EN`; `32'h55` in the following cycle in both builds.
- HI/LO: `hilo_we_i`=1 with `hi_i`=`32'h1`, `lo_i`=`32'h2` → next cycle `hi_o`=1, `lo_o`=2. Values hold while `hilo_we_i`=0 and are cleared by `rst`.
